// File: rtl/spi_controller_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : spi_controller_if
// Description : Control, write-stream, read-stream and SPI pin bundle for
//               spi_controller. The slave modport is the controller side;
//               the master modport is the host/bench side.
// Revision    : 1.0 - initial release
// ============================================================================
interface spi_controller_if #(
    parameter int COUNT_W = 16
) ();
    logic               start_in;
    logic [7:0]         opcode_in;
    logic [COUNT_W-1:0] wr_count_in;
    logic [COUNT_W-1:0] rd_count_in;
    logic [7:0]         wr_data_in;
    logic               wr_data_valid_in;
    logic               wr_data_ready_out;
    logic [7:0]         rd_data_out;
    logic               rd_data_valid_out;
    logic               busy_out;
    logic               done_out;
    logic               spi_select_out;
    logic               spi_clock_out;
    logic               spi_data_out;
    logic               spi_data_in;

    modport slave (
        input  start_in, opcode_in, wr_count_in, rd_count_in,
               wr_data_in, wr_data_valid_in, spi_data_in,
        output wr_data_ready_out, rd_data_out, rd_data_valid_out,
               busy_out, done_out, spi_select_out, spi_clock_out, spi_data_out
    );

    modport master (
        output start_in, opcode_in, wr_count_in, rd_count_in,
               wr_data_in, wr_data_valid_in, spi_data_in,
        input  wr_data_ready_out, rd_data_out, rd_data_valid_out,
               busy_out, done_out, spi_select_out, spi_clock_out, spi_data_out
    );
endinterface
`default_nettype wire

// File: rtl/spi_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : spi_controller
// Description : Mode-0, MSB-first SPI initiator. One transaction per start:
//               CS low, opcode byte, wr_count operand bytes from the write
//               stream, rd_count read bytes (MOSI held 0), CS high, gap.
//               Optional feature macro: SPI_CONTROLLER_LOOPBACK_EN adds the
//               loopback_in port, which routes MOSI into the MISO sampler.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_controller #(
    parameter int HALF_PERIOD = 2,   // clock cycles per SCK phase, >= 1
    parameter int CS_SETUP    = 2,   // >= 1
    parameter int CS_HOLD     = 2,   // >= 1
    parameter int CS_GAP      = 4,   // >= 1
    parameter int COUNT_W     = 16
) (
    input  wire logic       clock_in,
    input  wire logic       pll_reset,
`ifdef SPI_CONTROLLER_LOOPBACK_EN
    input  wire logic       loopback_in,
`endif
    spi_controller_if.slave bus
);

    localparam int TW = 16;
    localparam logic [TW-1:0] HALF_LAST  = TW'(HALF_PERIOD - 1);
    localparam logic [TW-1:0] SETUP_LAST = TW'(CS_SETUP - 1);
    localparam logic [TW-1:0] HOLD_LAST  = TW'(CS_HOLD - 1);
    localparam logic [TW-1:0] GAP_LAST   = TW'(CS_GAP - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        FETCH = 3'd3,
        HOLD  = 3'd4,
        GAP   = 3'd5
    } state_t;

    state_t             state;
    logic [TW-1:0]      timer;      // remaining cycles in SETUP/HOLD/GAP
    logic [TW-1:0]      half_cnt;   // position inside the current SCK phase
    logic [2:0]         bit_cnt;    // bit index inside the current byte
    logic [7:0]         tx_sr;      // outgoing byte, current bit at [7]
    logic [7:0]         rx_sr;      // incoming bits, newest at [0]
    logic [COUNT_W-1:0] wr_left;
    logic [COUNT_W-1:0] rd_left;
    logic               reading;    // current byte is a read byte

    logic               busy;
    logic               done;
    logic               cs_n;
    logic               sck;
    logic               mosi;
    logic               ready;
    logic [7:0]         rd_data;
    logic               rd_valid;

    logic               miso_bit;
    logic               sck_rise;

    // First cycle of each SCK high phase is the MISO sample point
    assign sck_rise = sck && (half_cnt == '0);

`ifdef SPI_CONTROLLER_LOOPBACK_EN
    logic lb;

    // Loopback selection is frozen for the whole transaction
    always_ff @(posedge clock_in or posedge pll_reset) begin
        if (pll_reset) begin
            lb <= 1'b0;
        end else if (state == IDLE) begin
            lb <= loopback_in;
        end
    end

    assign miso_bit = lb ? mosi : bus.spi_data_in;
`else
    assign miso_bit = bus.spi_data_in;
`endif

    // Transaction sequencer with all pin and status outputs registered
    always_ff @(posedge clock_in or posedge pll_reset) begin
        if (pll_reset) begin
            state    <= IDLE;
            timer    <= '0;
            half_cnt <= '0;
            bit_cnt  <= '0;
            tx_sr    <= '0;
            rx_sr    <= '0;
            wr_left  <= '0;
            rd_left  <= '0;
            reading  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            cs_n     <= 1'b1;
            sck      <= 1'b0;
            mosi     <= 1'b0;
            ready    <= 1'b0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            done     <= 1'b0;
            rd_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start_in) begin
                        state   <= SETUP;
                        busy    <= 1'b1;
                        cs_n    <= 1'b0;
                        tx_sr   <= bus.opcode_in;
                        mosi    <= bus.opcode_in[7];
                        wr_left <= bus.wr_count_in;
                        rd_left <= bus.rd_count_in;
                        reading <= 1'b0;
                        timer   <= SETUP_LAST;
                    end
                end

                SETUP: begin
                    if (timer == '0) begin
                        state    <= SHIFT;
                        half_cnt <= '0;
                        bit_cnt  <= '0;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end

                SHIFT: begin
                    if (sck_rise) begin
                        rx_sr <= {rx_sr[6:0], miso_bit};
                        if ((bit_cnt == 3'd7) && reading) begin
                            rd_data  <= {rx_sr[6:0], miso_bit};
                            rd_valid <= 1'b1;
                        end
                    end
                    if (half_cnt != HALF_LAST) begin
                        half_cnt <= half_cnt + 1'b1;
                    end else begin
                        half_cnt <= '0;
                        if (!sck) begin
                            sck <= 1'b1;
                        end else begin
                            sck <= 1'b0;
                            if (bit_cnt != 3'd7) begin
                                // MOSI only moves on the falling edge
                                bit_cnt <= bit_cnt + 1'b1;
                                tx_sr   <= {tx_sr[6:0], 1'b0};
                                mosi    <= tx_sr[6];
                            end else begin
                                bit_cnt <= '0;
                                if (wr_left != '0) begin
                                    state <= FETCH;
                                    ready <= 1'b1;
                                end else if (rd_left != '0) begin
                                    rd_left <= rd_left - 1'b1;
                                    reading <= 1'b1;
                                    tx_sr   <= '0;
                                    mosi    <= 1'b0;
                                end else begin
                                    state <= HOLD;
                                    timer <= HOLD_LAST;
                                    mosi  <= 1'b0;
                                end
                            end
                        end
                    end
                end

                FETCH: begin
                    // SCK stays low and CS stays asserted until data arrives
                    if (bus.wr_data_valid_in) begin
                        state    <= SHIFT;
                        ready    <= 1'b0;
                        tx_sr    <= bus.wr_data_in;
                        mosi     <= bus.wr_data_in[7];
                        wr_left  <= wr_left - 1'b1;
                        reading  <= 1'b0;
                        half_cnt <= '0;
                        bit_cnt  <= '0;
                    end
                end

                HOLD: begin
                    if (timer == '0) begin
                        state <= GAP;
                        cs_n  <= 1'b1;
                        timer <= GAP_LAST;
                        done  <= (CS_GAP == 1);
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end

                GAP: begin
                    if (timer == '0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        timer <= timer - 1'b1;
                        done  <= (timer == TW'(1));
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.wr_data_ready_out = ready;
    assign bus.rd_data_out       = rd_data;
    assign bus.rd_data_valid_out = rd_valid;
    assign bus.busy_out          = busy;
    assign bus.done_out          = done;
    assign bus.spi_select_out    = cs_n;
    assign bus.spi_clock_out     = sck;
    assign bus.spi_data_out      = mosi;

endmodule
`default_nettype wire

// File: tb/tb_spi_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_spi_controller
// Description : Directed bench for spi_controller. A transaction-level model
//               (byte lists, cycle budget) predicts pins and status each
//               cycle; a bench-side peripheral supplies MISO and a write
//               stream source supplies operand bytes.
//               Define SPI_CONTROLLER_LOOPBACK_EN to also cover loopback.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_controller;

    localparam int HP      = 2;
    localparam int SETUP_C = 2;
    localparam int HOLD_C  = 2;
    localparam int GAP_C   = 4;
    localparam int CW      = 16;

    logic clk = 1'b0;
    logic pll_reset;
    logic loopback;

    spi_controller_if #(.COUNT_W(CW)) bus ();

    spi_controller #(
        .HALF_PERIOD (HP),
        .CS_SETUP    (SETUP_C),
        .CS_HOLD     (HOLD_C),
        .CS_GAP      (GAP_C),
        .COUNT_W     (CW)
    ) dut (
        .clock_in    (clk),
        .pll_reset   (pll_reset),
`ifdef SPI_CONTROLLER_LOOPBACK_EN
        .loopback_in (loopback),
`endif
        .bus         (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Transaction model, written by the driver only
    logic [7:0] wbytes[$];
    logic [7:0] rbytes[$];
    logic [7:0] exp_mosi[$];
    logic [7:0] miso_bytes[$];
    logic [7:0] exp_rd[$];
    bit         act = 0;
    int         acc = 0;
    int         total = 0;
    int         nbytes = 0;
    int         first_read = 0;
    int         exp_ready = 0;
    int         lit_total = 0;
    int         stall_cfg = 0;
    bit         garbage_en = 0;
    bit         lb_on = 0;

    // Checker state, written by the checker only
    int         tests = 0;
    int         fails = 0;
    int         rel, b, rises, ready_cycles, rd_idx, widx, stall_left;
    bit         in_txn, pend, prev_sck, prev_mosi;
    logic [7:0] mb;
    logic [31:0] rexp;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d, rel %0d)", name, got, exp, cyc, cyc - acc);
        end
    endtask

    // Per-cycle compare, MISO peripheral and write-stream source
    always @(negedge clk) begin
        rel    = cyc - acc;
        in_txn = act && (rel >= 0) && (rel <= total - 1);
        if (pll_reset) begin
            chk("rst_select", bus.spi_select_out, 1);
            chk("rst_sck", bus.spi_clock_out, 0);
            chk("rst_mosi", bus.spi_data_out, 0);
            chk("rst_busy", bus.busy_out, 0);
            chk("rst_done", bus.done_out, 0);
            chk("rst_ready", bus.wr_data_ready_out, 0);
            chk("rst_rd_valid", bus.rd_data_valid_out, 0);
            chk("rst_rd_data", bus.rd_data_out, 0);
            pend = 0;
            bus.wr_data_valid_in = 0;
            bus.wr_data_in = 0;
            bus.spi_data_in = 0;
        end else begin
            if (in_txn && rel == 0) begin
                rises = 0; ready_cycles = 0; rd_idx = 0; widx = 0;
                stall_left = stall_cfg;
            end
            chk("busy", bus.busy_out, in_txn);
            chk("done", bus.done_out, in_txn && (rel == total - 1));
            chk("select", bus.spi_select_out, !(in_txn && (rel < total - GAP_C)));
            if (!in_txn) chk("ready_idle", bus.wr_data_ready_out, 0);
            if (bus.spi_select_out || bus.wr_data_ready_out) chk("sck_low", bus.spi_clock_out, 0);
            chk("rd_valid", bus.rd_data_valid_out, pend);
            if (bus.rd_data_valid_out) begin
                rexp = (rd_idx < exp_rd.size()) ? {24'd0, exp_rd[rd_idx]} : 32'h100;
                chk("rd_data", bus.rd_data_out, rexp);
                rd_idx++;
            end
            if (bus.done_out && lit_total != 0) chk("done_cycle", rel + 1, lit_total);
            pend = 0;
            if (in_txn) begin
                if (bus.wr_data_ready_out) ready_cycles++;
                if (bus.spi_clock_out && !prev_sck) begin
                    b  = rises / 8;
                    mb = (b < exp_mosi.size()) ? exp_mosi[b] : 8'h00;
                    chk("mosi_bit", bus.spi_data_out, mb[7 - (rises % 8)]);
                    rises++;
                    if ((rises % 8 == 0) && (b >= first_read)) pend = 1;
                end
                if (bus.spi_clock_out && prev_sck) chk("mosi_stable", bus.spi_data_out, prev_mosi);
                if (!bus.spi_clock_out) begin
                    b  = rises / 8;
                    mb = (b < miso_bytes.size()) ? miso_bytes[b] : 8'h00;
                    bus.spi_data_in = mb[7 - (rises % 8)];
                end
                if (bus.wr_data_ready_out && widx < wbytes.size()) begin
                    if (stall_left > 0) begin
                        stall_left--;
                        bus.wr_data_valid_in = 0;
                    end else begin
                        bus.wr_data_valid_in = 1;
                        bus.wr_data_in = wbytes[widx];
                        widx++;
                        stall_left = stall_cfg;
                    end
                end else begin
                    bus.wr_data_valid_in = garbage_en;
                    bus.wr_data_in = 8'hEE;
                end
                if (rel == total - 1) begin
                    chk("sck_pulses", rises, 8 * nbytes);
                    chk("rd_count", rd_idx, exp_rd.size());
                    chk("ready_cycles", ready_cycles, exp_ready);
                end
            end else begin
                bus.wr_data_valid_in = garbage_en;
                bus.wr_data_in = 8'hEE;
            end
            prev_sck  = bus.spi_clock_out;
            prev_mosi = bus.spi_data_out;
        end
    end

    // Build the expected byte lists and cycle budget, then issue the start
    task automatic begin_txn(input logic [7:0] op, input int rd, input int stall, input int lit);
        exp_mosi = {}; miso_bytes = {}; exp_rd = {};
        exp_mosi.push_back(op);
        miso_bytes.push_back(8'hA5);
        foreach (wbytes[i]) begin
            exp_mosi.push_back(wbytes[i]);
            miso_bytes.push_back(8'hA5);
        end
        for (int i = 0; i < rd; i++) begin
            exp_mosi.push_back(8'h00);
            miso_bytes.push_back(rbytes[i]);
            exp_rd.push_back(lb_on ? 8'h00 : rbytes[i]);
        end
        nbytes     = 1 + wbytes.size() + rd;
        first_read = 1 + wbytes.size();
        exp_ready  = wbytes.size() * (stall + 1);
        total      = SETUP_C + nbytes * 16 * HP + exp_ready + HOLD_C + GAP_C;
        lit_total  = lit;
        stall_cfg  = stall;
        @(negedge clk);
        bus.start_in    = 1;
        bus.opcode_in   = op;
        bus.wr_count_in = CW'(wbytes.size());
        bus.rd_count_in = CW'(rd);
        @(posedge clk);
        #1;
        bus.start_in    = 0;
        bus.opcode_in   = 8'h00;
        bus.wr_count_in = '0;
        bus.rd_count_in = '0;
        acc = cyc;
        act = 1;
    endtask

    // Full transaction; optionally pokes start while busy (mid-run and last GAP cycle)
    task automatic run_txn(input logic [7:0] op, input int rd, input int stall, input int lit, input bit poke);
        int wait_c;
        begin_txn(op, rd, stall, lit);
        wait_c = total + 3;
        for (int k = 0; k < wait_c; k++) begin
            @(posedge clk);
            #1;
            bus.start_in    = poke && (k == 10 || k == total - 2);
            bus.opcode_in   = bus.start_in ? 8'h77 : 8'h00;
            bus.wr_count_in = bus.start_in ? CW'(5) : CW'(0);
            bus.rd_count_in = bus.start_in ? CW'(5) : CW'(0);
        end
        act = 0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        pll_reset            = 1;
        loopback             = 0;
        bus.start_in         = 0;
        bus.opcode_in        = 0;
        bus.wr_count_in      = 0;
        bus.rd_count_in      = 0;
        repeat (5) @(posedge clk);
        #3 pll_reset = 0;
        repeat (3) @(posedge clk);
        #1;

        // Chip ID read: 2 + 64 + 2 + 4 = 72 cycles, start while busy ignored
        wbytes = {}; rbytes = {8'h81};
        run_txn(8'hDB, 1, 0, 72, 1);

        // Three operand writes, valid also asserted outside FETCH: 2+128+3+2+4
        wbytes = {8'hAA, 8'h55, 8'h01}; rbytes = {};
        garbage_en = 1;
        run_txn(8'h10, 0, 0, 139, 0);
        garbage_en = 0;

        // Write stream withheld 20 cycles, then one read: 2+96+21+2+4
        wbytes = {8'h5A}; rbytes = {8'h3C};
        run_txn(8'h20, 1, 20, 125, 0);

        // Opcode only: 2+32+2+4
        wbytes = {}; rbytes = {};
        run_txn(8'h9F, 0, 0, 40, 0);

        // Writes then two reads: 2+160+2+2+4
        wbytes = {8'h12, 8'h34}; rbytes = {8'hDE, 8'hAD};
        run_txn(8'h0B, 2, 0, 170, 0);

        // Reset during bit 3 of the opcode, then a clean chip ID read
        wbytes = {}; rbytes = {8'h81};
        begin_txn(8'hDB, 1, 0, 72);
        for (int k = 0; k < 15; k++) @(posedge clk);
        #1;
        act = 0;
        pll_reset = 1;
        repeat (3) @(posedge clk);
        #3 pll_reset = 0;
        repeat (4) @(posedge clk);
        #1;
        run_txn(8'hDB, 1, 0, 72, 0);

`ifdef SPI_CONTROLLER_LOOPBACK_EN
        // Loopback: read byte echoes MOSI, which is 0 during reads: 2+96+1+2+4
        loopback = 1; lb_on = 1;
        wbytes = {8'hC3}; rbytes = {8'h81};
        run_txn(8'h3C, 1, 0, 105, 0);
        wbytes = {}; rbytes = {};
        run_txn(8'h3C, 0, 0, 40, 0);
        loopback = 0; lb_on = 0;
        repeat (2) @(posedge clk);
        #1;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
